matmul_apb_ctrl: RTL and testbench

- APB slave front-end and calculation sequencer of the matmul accelerator.
- Decodes APB accesses into operand-buffer writes, the control register, the flags register and scratchpad (SP) reads.
- Launches the systolic datapath, drives busy_o and latches result flags on completion.
- Sits between the APB bus (driven by the matmul stimulus/CPU) and the operand buffers, matmul core and SP.

---
 rtl/matmul_apb_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_matmul_apb_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_apb_ctrl.sv
// APB slave front-end and calculation sequencer for the matmul accelerator.
// Decodes APB transfers to operand writes, CONTROL/FLAGS registers and SP reads, and launches the core.
module matmul_apb_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  parameter int SP_NTARGETS = 4,
  localparam int LINE_W     = $clog2(MAX_DIM),
  localparam int TGT_W      = $clog2(SP_NTARGETS),
  localparam int FLAG_W     = MAX_DIM * MAX_DIM
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [MAX_DIM-1:0]    pstrb_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  busy_o,
  output logic                  opa_we_o,
  output logic                  opb_we_o,
  output logic [LINE_W-1:0]     op_line_o,
  output logic [BUS_WIDTH-1:0]  op_wdata_o,
  output logic [MAX_DIM-1:0]    op_wstrb_o,
  output logic                  calc_start_o,
  output logic [LINE_W-1:0]     calc_n_o,
  output logic [LINE_W-1:0]     calc_k_o,
  output logic [LINE_W-1:0]     calc_m_o,
  output logic                  calc_mode_o,
  output logic [TGT_W-1:0]      calc_wr_tgt_o,
  output logic [TGT_W-1:0]      calc_rd_tgt_o,
  input  logic                  calc_done_i,
  input  logic [FLAG_W-1:0]     calc_flags_i,
  output logic                  sp_rd_o,
  output logic [TGT_W-1:0]      sp_tgt_o,
  output logic [LINE_W-1:0]     sp_line_o,
  input  logic                  sp_rvalid_i,
  input  logic [BUS_WIDTH-1:0]  sp_rdata_i
);

  localparam logic [4:0] REG_CONTROL   = 5'h00;
  localparam logic [4:0] REG_OPERAND_A = 5'h04;
  localparam logic [4:0] REG_OPERAND_B = 5'h08;
  localparam logic [4:0] REG_FLAGS     = 5'h0C;
  localparam logic [4:0] REG_SP        = 5'h10;

  // SETUP is the registered "setup seen" state; its penable cycle is the first access cycle.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  typedef enum logic [1:0] {C_IDLE, C_START, C_RUN, C_DONE} calc_state_t;

  apb_state_t  apb_q, apb_d;
  calc_state_t calc_q, calc_d;

  logic              ctrl_start_q;
  logic              ctrl_mode_q;
  logic [TGT_W-1:0]  ctrl_wr_tgt_q;
  logic [TGT_W-1:0]  ctrl_rd_tgt_q;
  logic [LINE_W-1:0] ctrl_n_q;
  logic [LINE_W-1:0] ctrl_k_q;
  logic [LINE_W-1:0] ctrl_m_q;
  logic [FLAG_W-1:0] flags_q;

  logic [4:0]          region;
  logic [LINE_W-1:0]   line;
  logic                is_ctrl, is_opa, is_opb, is_flags, is_sp, is_illegal;
  logic                busy;
  logic                xfer_err;
  logic                ctrl_wr_ok;
  logic                flags_rd_ok;
  logic                op_we;
  logic                sp_active;
  logic [BUS_WIDTH-1:0] ctrl_rdata;
  logic                unused_addr;

  assign region      = paddr_i[4:0];
  assign line        = paddr_i[5 +: LINE_W];
  assign unused_addr = ^paddr_i[ADDR_WIDTH-1:5+LINE_W];

  assign is_ctrl    = (region == REG_CONTROL);
  assign is_opa     = (region == REG_OPERAND_A);
  assign is_opb     = (region == REG_OPERAND_B);
  assign is_flags   = (region == REG_FLAGS);
  assign is_sp      = (region == REG_SP);
  assign is_illegal = !(is_ctrl || is_opa || is_opb || is_flags || is_sp);

  assign busy = (calc_q != C_IDLE);

  // Erroring transfers complete with pslverr and have no side effects at all.
  assign xfer_err = is_illegal
                 || (pwrite_i && (is_flags || is_sp))
                 || (!pwrite_i && (is_opa || is_opb))
                 || (pwrite_i && busy && (is_opa || is_opb || is_ctrl));

  always_comb begin
    ctrl_rdata = '0;
    ctrl_rdata[0]               = ctrl_start_q;
    ctrl_rdata[1]               = ctrl_mode_q;
    ctrl_rdata[2 +: TGT_W]      = ctrl_wr_tgt_q;
    ctrl_rdata[4 +: TGT_W]      = ctrl_rd_tgt_q;
    ctrl_rdata[8 +: LINE_W]     = ctrl_n_q;
    ctrl_rdata[10 +: LINE_W]    = ctrl_k_q;
    ctrl_rdata[12 +: LINE_W]    = ctrl_m_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      apb_q  <= IDLE;
      calc_q <= C_IDLE;
    end else begin
      apb_q  <= apb_d;
      calc_q <= calc_d;
    end
  end

  always_comb begin
    apb_d       = apb_q;
    pready_o    = 1'b0;
    pslverr_o   = 1'b0;
    prdata_o    = '0;
    opa_we_o    = 1'b0;
    opb_we_o    = 1'b0;
    sp_rd_o     = 1'b0;
    ctrl_wr_ok  = 1'b0;
    flags_rd_ok = 1'b0;
    case (apb_q)
      IDLE: begin
        if (psel_i && !penable_i) apb_d = SETUP;
      end
      SETUP: begin
        if (!psel_i) begin
          apb_d = IDLE;
        end else if (penable_i) begin
          if (xfer_err) begin
            pready_o  = 1'b1;
            pslverr_o = 1'b1;
            apb_d     = IDLE;
          end else if (is_sp) begin
            sp_rd_o = 1'b1;
            if (sp_rvalid_i) begin
              pready_o = 1'b1;
              prdata_o = sp_rdata_i;
              apb_d    = IDLE;
            end else begin
              apb_d = ACCESS;
            end
          end else begin
            pready_o    = 1'b1;
            apb_d       = IDLE;
            opa_we_o    = pwrite_i && is_opa;
            opb_we_o    = pwrite_i && is_opb;
            ctrl_wr_ok  = pwrite_i && is_ctrl;
            flags_rd_ok = !pwrite_i && is_flags;
            if (!pwrite_i && is_ctrl)  prdata_o = ctrl_rdata;
            if (!pwrite_i && is_flags) prdata_o = BUS_WIDTH'(flags_q);
          end
        end
      end
      ACCESS: begin
        // Only SP reads park here, waiting for the scratchpad to return data.
        if (!psel_i) begin
          apb_d = IDLE;
        end else if (sp_rvalid_i) begin
          pready_o = 1'b1;
          prdata_o = sp_rdata_i;
          apb_d    = IDLE;
        end
      end
      default: apb_d = IDLE;
    endcase
  end

  assign op_we      = opa_we_o || opb_we_o;
  assign op_line_o  = op_we ? line : '0;
  assign op_wdata_o = op_we ? pwdata_i : '0;
  assign op_wstrb_o = op_we ? pstrb_i : '0;

  assign sp_active  = sp_rd_o || (apb_q == ACCESS);
  assign sp_tgt_o   = sp_active ? ctrl_rd_tgt_q : '0;
  assign sp_line_o  = sp_active ? line : '0;

  always_comb begin
    calc_d       = calc_q;
    calc_start_o = 1'b0;
    case (calc_q)
      C_IDLE:  if (ctrl_wr_ok && pwdata_i[0]) calc_d = C_START;
      C_START: begin
        calc_start_o = 1'b1;
        calc_d       = C_RUN;
      end
      C_RUN:   if (calc_done_i) calc_d = C_DONE;
      C_DONE:  calc_d = C_IDLE;
      default: calc_d = C_IDLE;
    endcase
  end

  assign busy_o = busy;

  // Control fields only change on accepted writes, which cannot happen while busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_start_q  <= 1'b0;
      ctrl_mode_q   <= 1'b0;
      ctrl_wr_tgt_q <= '0;
      ctrl_rd_tgt_q <= '0;
      ctrl_n_q      <= '0;
      ctrl_k_q      <= '0;
      ctrl_m_q      <= '0;
    end else if (ctrl_wr_ok) begin
      ctrl_start_q  <= pwdata_i[0];
      ctrl_mode_q   <= pwdata_i[1];
      ctrl_wr_tgt_q <= pwdata_i[2 +: TGT_W];
      ctrl_rd_tgt_q <= pwdata_i[4 +: TGT_W];
      ctrl_n_q      <= pwdata_i[8 +: LINE_W];
      ctrl_k_q      <= pwdata_i[10 +: LINE_W];
      ctrl_m_q      <= pwdata_i[12 +: LINE_W];
    end else if (calc_q == C_DONE) begin
      ctrl_start_q  <= 1'b0;
    end
  end

  // A completing calculation takes priority over a read-to-clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else if (calc_q == C_RUN && calc_done_i) begin
      flags_q <= calc_flags_i;
    end else if (flags_rd_ok) begin
      flags_q <= '0;
    end
  end

  assign calc_mode_o   = ctrl_mode_q;
  assign calc_wr_tgt_o = ctrl_wr_tgt_q;
  assign calc_rd_tgt_o = ctrl_rd_tgt_q;
  assign calc_n_o      = ctrl_n_q;
  assign calc_k_o      = ctrl_k_q;
  assign calc_m_o      = ctrl_m_q;

endmodule

// File: tb/tb_matmul_apb_ctrl.sv
// Directed bench for matmul_apb_ctrl: a table of APB transfers plus hand-written calc/SP/reset sequences.
module tb_matmul_apb_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [15:0] paddr;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        busy, opaWe, opbWe;
  logic [1:0]  opLine;
  logic [31:0] opWdata;
  logic [3:0]  opWstrb;
  logic        calcStart;
  logic [1:0]  calcN, calcK, calcM;
  logic        calcMode;
  logic [1:0]  calcWrTgt, calcRdTgt;
  logic        calcDone;
  logic [15:0] calcFlags;
  logic        spRd;
  logic [1:0]  spTgt, spLine;
  logic        spRvalid;
  logic [31:0] spRdata;

  always #5 clk = ~clk;

  matmul_apb_ctrl dut (
    .clk_i(clk), .rst_ni(rstN),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .pstrb_i(pstrb),
    .pwdata_i(pwdata), .paddr_i(paddr),
    .pready_o(pready), .pslverr_o(pslverr), .prdata_o(prdata),
    .busy_o(busy), .opa_we_o(opaWe), .opb_we_o(opbWe),
    .op_line_o(opLine), .op_wdata_o(opWdata), .op_wstrb_o(opWstrb),
    .calc_start_o(calcStart), .calc_n_o(calcN), .calc_k_o(calcK), .calc_m_o(calcM),
    .calc_mode_o(calcMode), .calc_wr_tgt_o(calcWrTgt), .calc_rd_tgt_o(calcRdTgt),
    .calc_done_i(calcDone), .calc_flags_i(calcFlags),
    .sp_rd_o(spRd), .sp_tgt_o(spTgt), .sp_line_o(spLine),
    .sp_rvalid_i(spRvalid), .sp_rdata_i(spRdata)
  );

  logic anyOut;
  assign anyOut = |{pready, pslverr, prdata, busy, opaWe, opbWe, opLine, opWdata, opWstrb,
                    calcStart, calcN, calcK, calcM, calcMode, calcWrTgt, calcRdTgt,
                    spRd, spTgt, spLine};

  // Scratchpad stand-in: answers spDelay cycles after the read request.
  int          spDelay = 3;
  int          spCnt = 0;
  logic [31:0] spData = 32'h0;
  logic [1:0]  spLineSeen = 2'b0, spTgtSeen = 2'b0;
  assign spRvalid = (spCnt == 1);
  assign spRdata  = spRvalid ? spData : 32'h0;

  always @(posedge clk) begin
    if (spRd) begin
      spCnt      <= spDelay;
      spLineSeen <= spLine;
      spTgtSeen  <= spTgt;
    end else if (spCnt != 0) begin
      spCnt <= spCnt - 1;
    end
  end

  int opaCount = 0, opbCount = 0, startCount = 0, spRdCount = 0;
  always @(negedge clk) begin
    if (opaWe) opaCount++;
    if (opbWe) opbCount++;
    if (calcStart) startCount++;
    if (spRd) spRdCount++;
  end

  int checkCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  logic [31:0] xRdata, xOpWdata;
  logic        xErr;
  logic [1:0]  xOpLine;
  logic [3:0]  xOpWstrb;
  int          xWaits;

  task automatic applyStimulus(input bit write, input logic [15:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input bit doneWithAccess);
    bit seen;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = write; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    if (doneWithAccess) calcDone = 1'b1;
    xWaits = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (pready) begin
        seen     = 1'b1;
        xRdata   = prdata;
        xErr     = pslverr;
        xOpLine  = opLine;
        xOpWdata = opWdata;
        xOpWstrb = opWstrb;
      end else begin
        xWaits++;
      end
    end
    if (!seen) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL pready timeout: got 0, expected 1 within 50 cycles (addr 0x%04h)", addr);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0; pwdata = 32'h0; pstrb = 4'h0;
    calcDone = 1'b0;
  endtask

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          expErr;
    logic [31:0] expRdata;
    int          expOpa;
    int          expOpb;
    logic [1:0]  expLine;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int opaB, opbB, spB, startB;
    bit fell;

    vecs[0]  = '{0, 16'h0000, 32'h0,        4'h0, 0, 32'h0,        0, 0, 2'd0};
    vecs[1]  = '{1, 16'h0044, 32'h04030201, 4'hF, 0, 32'h0,        1, 0, 2'd2};
    vecs[2]  = '{1, 16'h0068, 32'hA1B2C3D4, 4'h5, 0, 32'h0,        0, 1, 2'd3};
    vecs[3]  = '{0, 16'h0004, 32'h0,        4'h0, 1, 32'h0,        0, 0, 2'd0};
    vecs[4]  = '{0, 16'h0008, 32'h0,        4'h0, 1, 32'h0,        0, 0, 2'd0};
    vecs[5]  = '{1, 16'h000C, 32'h12345678, 4'hF, 1, 32'h0,        0, 0, 2'd0};
    vecs[6]  = '{1, 16'h0010, 32'h12345678, 4'hF, 1, 32'h0,        0, 0, 2'd0};
    vecs[7]  = '{0, 16'h0014, 32'h0,        4'h0, 1, 32'h0,        0, 0, 2'd0};
    vecs[8]  = '{1, 16'h001F, 32'hFFFFFFFF, 4'hF, 1, 32'h0,        0, 0, 2'd0};
    vecs[9]  = '{1, 16'h0000, 32'hF0F03AE6, 4'hF, 0, 32'h0,        0, 0, 2'd0};
    vecs[10] = '{0, 16'h0000, 32'h0,        4'h0, 0, 32'h00003A26, 0, 0, 2'd0};
    vecs[11] = '{0, 16'h000C, 32'h0,        4'h0, 0, 32'h0,        0, 0, 2'd0};

    rstN = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0044;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; calcDone = 1'b0; calcFlags = 16'hFFFF;
    repeat (2) @(negedge clk);
    checkOutput("reset outputs zero", {31'b0, anyOut}, 32'h0);
    @(posedge clk); #1;
    rstN = 1'b1; calcFlags = 16'h0;

    for (int i = 0; i < 12; i++) begin
      opaB = opaCount; opbB = opbCount;
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0);
      checkOutput($sformatf("vec%0d waits", i), xWaits, 0);
      checkOutput($sformatf("vec%0d pslverr", i), {31'b0, xErr}, {31'b0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d prdata", i), xRdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d opa pulses", i), opaCount - opaB, vecs[i].expOpa);
      checkOutput($sformatf("vec%0d opb pulses", i), opbCount - opbB, vecs[i].expOpb);
      if (vecs[i].expOpa + vecs[i].expOpb > 0) begin
        checkOutput($sformatf("vec%0d op_line", i), {30'b0, xOpLine}, {30'b0, vecs[i].expLine});
        checkOutput($sformatf("vec%0d op_wdata", i), xOpWdata, vecs[i].wdata);
        checkOutput($sformatf("vec%0d op_wstrb", i), {28'b0, xOpWstrb}, {28'b0, vecs[i].strb});
      end
    end

    @(negedge clk);
    checkOutput("ctrl mode", {31'b0, calcMode}, 32'd1);
    checkOutput("ctrl wr_tgt", {30'b0, calcWrTgt}, 32'd1);
    checkOutput("ctrl rd_tgt", {30'b0, calcRdTgt}, 32'd2);
    checkOutput("ctrl n/k/m", {26'b0, calcN, calcK, calcM}, {26'b0, 2'd2, 2'd2, 2'd3});
    checkOutput("no launch on start=0", startCount, 0);

    spDelay = 3; spData = 32'hDEADBEEF; spB = spRdCount;
    applyStimulus(0, 16'h0030, 32'h0, 4'h0, 0);
    checkOutput("sp waits", xWaits, 3);
    checkOutput("sp prdata", xRdata, 32'hDEADBEEF);
    checkOutput("sp pslverr", {31'b0, xErr}, 32'h0);
    checkOutput("sp_rd pulses", spRdCount - spB, 1);
    checkOutput("sp line", {30'b0, spLineSeen}, 32'd1);
    checkOutput("sp target", {30'b0, spTgtSeen}, 32'd2);
    spDelay = 1; spData = 32'h12345678;
    applyStimulus(0, 16'h0070, 32'h0, 4'h0, 0);
    checkOutput("sp short waits", xWaits, 1);
    checkOutput("sp short prdata", xRdata, 32'h12345678);

    startB = startCount;
    applyStimulus(1, 16'h0000, 32'h00003F01, 4'hF, 0);
    @(negedge clk);
    checkOutput("calc_start pulse", {31'b0, calcStart}, 32'd1);
    checkOutput("busy rises", {31'b0, busy}, 32'd1);
    checkOutput("calc n/k/m full", {26'b0, calcN, calcK, calcM}, 32'h3F);
    @(negedge clk);
    checkOutput("calc_start one cycle", {31'b0, calcStart}, 32'd0);
    opbB = opbCount;
    applyStimulus(1, 16'h0008, 32'h55555555, 4'hF, 0);
    checkOutput("opb while busy err", {31'b0, xErr}, 32'd1);
    checkOutput("opb while busy no we", opbCount - opbB, 0);
    applyStimulus(1, 16'h0000, 32'h00000000, 4'hF, 0);
    checkOutput("ctrl write busy err", {31'b0, xErr}, 32'd1);
    applyStimulus(0, 16'h0000, 32'h0, 4'h0, 0);
    checkOutput("ctrl read busy", xRdata, 32'h00003F01);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0);
    checkOutput("flags read busy", xRdata, 32'h0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("busy held", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    calcDone = 1'b1; calcFlags = 16'h0005;
    @(posedge clk); #1;
    calcDone = 1'b0; calcFlags = 16'h0;
    @(negedge clk);
    checkOutput("busy in done cycle", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("busy falls", {31'b0, busy}, 32'd0);
    checkOutput("single launch", startCount - startB, 1);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0);
    checkOutput("flags latched", xRdata, 32'h00000005);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0);
    checkOutput("flags cleared", xRdata, 32'h0);
    applyStimulus(0, 16'h0000, 32'h0, 4'h0, 0);
    checkOutput("start auto-clear", xRdata, 32'h00003F00);

    @(posedge clk); #1;
    calcDone = 1'b1; calcFlags = 16'hFFFF;
    @(posedge clk); #1;
    calcDone = 1'b0; calcFlags = 16'h0;
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0);
    checkOutput("done ignored idle", xRdata, 32'h0);

    applyStimulus(1, 16'h0000, 32'h00000001, 4'hF, 0);
    calcFlags = 16'h00A0;
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 1);
    calcFlags = 16'h0;
    checkOutput("flags read vs done old", xRdata, 32'h0);
    fell = 1'b0;
    for (int i = 0; i < 10 && !fell; i++) begin
      @(negedge clk);
      if (!busy) fell = 1'b1;
    end
    checkOutput("busy falls bounded", {31'b0, fell}, 32'd1);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0);
    checkOutput("done wins over clear", xRdata, 32'h000000A0);

    startB = startCount;
    applyStimulus(1, 16'h0000, 32'h00000001, 4'hF, 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b0;
    @(negedge clk);
    checkOutput("midrun reset outputs", {31'b0, anyOut}, 32'h0);
    @(posedge clk); #1;
    rstN = 1'b1; calcDone = 1'b1; calcFlags = 16'hFFFF;
    @(posedge clk); #1;
    calcDone = 1'b0; calcFlags = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("no restart busy", {31'b0, busy}, 32'd0);
    checkOutput("no restart start", startCount - startB, 1);
    applyStimulus(0, 16'h000C, 32'h0, 4'h0, 0);
    checkOutput("flags after reset", xRdata, 32'h0);
    applyStimulus(0, 16'h0000, 32'h0, 4'h0, 0);
    checkOutput("ctrl after reset", xRdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
